// File: rtl/bubble_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_host_pkg
//  Description : Shared definitions for the bubble host sequencer: sequencer
//                state enumeration, default widths and default timing
//                intervals (in master_clock cycles). The widths are also
//                shared with the drive top's timing generator.
//  Revision    : 1.0  initial release
// ============================================================================
package bubble_host_pkg;

    localparam int c_cnt_w          = 24;
    localparam int c_page_w         = 12;

    localparam int c_t_boot_shift   = 2193872;
    localparam int c_t_boot_loop    = 211;
    localparam int c_t_rep_delay    = 500;
    localparam int c_t_rep_width    = 341;
    localparam int c_t_shift_tail   = 336991;
    localparam int c_t_gap          = 37500;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_BOOT_SHIFT = 4'd1,
        ST_BOOT_WAIT  = 4'd2,
        ST_SEEK       = 4'd3,
        ST_REP_PULSE  = 4'd4,
        ST_SHIFT_TAIL = 4'd5,
        ST_GAP        = 4'd6,
        ST_REP_DELAY  = 4'd7,
        ST_DONE       = 4'd8
    } state_t;

    // Busy covers every state except the two resting ones.
    function automatic logic is_busy(input state_t s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

    // States in which the host holds the shift request low.
    function automatic logic shift_low(input state_t s);
        return (s == ST_BOOT_SHIFT) || (s == ST_SEEK) || (s == ST_REP_PULSE) ||
               (s == ST_SHIFT_TAIL) || (s == ST_REP_DELAY);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bubble_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_interval_timer
//  Description : Loadable down-counter used to time every sequencer state.
//                A load of T programs T-1 so that o_zero is reached after
//                exactly T cycles; a load of 0 behaves like 1.
//  Ports       : clk, rst_n (async, active-low), i_load, i_load_val[CNT_W],
//                o_zero (counter currently reads 0)
//  Revision    : 1.0  initial release
// ============================================================================
module bubble_interval_timer
    import bubble_host_pkg::*;
#(
    parameter int CNT_W = c_cnt_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= (i_load_val == '0) ? '0 : (i_load_val - CNT_W'(1));
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/bubble_host_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_host_sequencer
//  Description : Host-side access sequencer for the bubble drive emulator.
//                Runs a bootloader phase (boot_start) or a multi-page read
//                burst (read_start), driving the active-low shift and
//                replicate strobes and the bootloop flag.
//  Ports       : master_clock, power_good (async active-low reset),
//                boot_start, read_start, abort, page_start[PAGE_W],
//                page_count[PAGE_W], seek_delay[CNT_W] ->
//                bubble_shift_enable, replicator_enable, bootloop_enable,
//                busy, done, page_addr[PAGE_W]
//  Revision    : 1.0  initial release
// ============================================================================
module bubble_host_sequencer
    import bubble_host_pkg::*;
#(
    parameter int CNT_W        = c_cnt_w,
    parameter int PAGE_W       = c_page_w,
    parameter int T_BOOT_SHIFT = c_t_boot_shift,
    parameter int T_BOOT_LOOP  = c_t_boot_loop,
    parameter int T_REP_DELAY  = c_t_rep_delay,
    parameter int T_REP_WIDTH  = c_t_rep_width,
    parameter int T_SHIFT_TAIL = c_t_shift_tail,
    parameter int T_GAP        = c_t_gap
) (
    input  logic              master_clock,
    input  logic              power_good,
    input  logic              boot_start,
    input  logic              read_start,
    input  logic              abort,
    input  logic [PAGE_W-1:0] page_start,
    input  logic [PAGE_W-1:0] page_count,
    input  logic [CNT_W-1:0]  seek_delay,
    output logic              bubble_shift_enable,
    output logic              replicator_enable,
    output logic              bootloop_enable,
    output logic              busy,
    output logic              done,
    output logic [PAGE_W-1:0] page_addr
);

    state_t            r_state;
    state_t            w_next;
    logic [PAGE_W-1:0] r_remaining;
    logic              w_empty_req;
    logic              w_load;
    logic [CNT_W-1:0]  w_load_val;
    logic              w_zero;

    // Next-state decision. The timer is reloaded on every state change so
    // that the interval for the new state starts on the entry edge.
    always_comb begin
        w_next      = r_state;
        w_empty_req = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!abort) begin
                    if (boot_start) begin
                        w_next = ST_BOOT_SHIFT;
                    end else if (read_start) begin
                        if (page_count != '0) begin
                            w_next = ST_SEEK;
                        end else begin
                            w_empty_req = 1'b1;
                        end
                    end
                end
            end
            ST_BOOT_SHIFT: if (w_zero) w_next = ST_BOOT_WAIT;
            ST_BOOT_WAIT:  if (w_zero) w_next = ST_DONE;
            ST_SEEK:       if (w_zero) w_next = ST_REP_PULSE;
            ST_REP_PULSE:  if (w_zero) w_next = ST_SHIFT_TAIL;
            ST_SHIFT_TAIL: begin
                // Remaining is decremented on this exit, so 1 means last page.
                if (w_zero) w_next = (r_remaining == PAGE_W'(1)) ? ST_DONE : ST_GAP;
            end
            ST_GAP:        if (w_zero) w_next = ST_REP_DELAY;
            ST_REP_DELAY:  if (w_zero) w_next = ST_REP_PULSE;
            ST_DONE:       w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
        if (abort && is_busy(r_state)) begin
            w_next = ST_IDLE;
        end
    end

    assign w_load = (w_next != r_state);

    always_comb begin
        w_load_val = '0;
        case (w_next)
            ST_BOOT_SHIFT: w_load_val = CNT_W'(T_BOOT_SHIFT);
            ST_BOOT_WAIT:  w_load_val = CNT_W'(T_BOOT_LOOP);
            ST_SEEK:       w_load_val = seek_delay;
            ST_REP_PULSE:  w_load_val = CNT_W'(T_REP_WIDTH);
            ST_SHIFT_TAIL: w_load_val = CNT_W'(T_SHIFT_TAIL);
            ST_GAP:        w_load_val = CNT_W'(T_GAP);
            ST_REP_DELAY:  w_load_val = CNT_W'(T_REP_DELAY);
            default:       w_load_val = '0;
        endcase
    end

    bubble_interval_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (master_clock),
        .rst_n      (power_good),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // Outputs are decoded from the state being entered so they change on the
    // entry edge and stay registered.
    always_ff @(posedge master_clock or negedge power_good) begin
        if (!power_good) begin
            r_state             <= ST_IDLE;
            r_remaining         <= '0;
            bubble_shift_enable <= 1'b1;
            replicator_enable   <= 1'b1;
            bootloop_enable     <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            page_addr           <= '0;
        end else begin
            r_state             <= w_next;
            bubble_shift_enable <= !shift_low(w_next);
            replicator_enable   <= (w_next != ST_REP_PULSE);
            busy                <= is_busy(w_next);
            done                <= (w_next == ST_DONE) || w_empty_req;

            // Sticky until power_good drops; abort leaves it alone.
            if ((r_state == ST_BOOT_WAIT) && (w_next == ST_DONE)) begin
                bootloop_enable <= 1'b1;
            end

            if ((r_state == ST_IDLE) && (w_next == ST_SEEK)) begin
                page_addr   <= page_start;
                r_remaining <= page_count;
            end else if ((r_state == ST_SHIFT_TAIL) && (w_next != r_state) && !abort) begin
                r_remaining <= r_remaining - PAGE_W'(1);
            end

            if ((r_state == ST_GAP) && (w_next == ST_REP_DELAY)) begin
                page_addr <= page_addr + PAGE_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bubble_host_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bubble_host_sequencer
//  Description : Self-checking bench for bubble_host_sequencer with short
//                timing parameters. Expected strobes are computed per cycle
//                from the burst timeline (page start times and interval
//                lengths) rather than from any state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bubble_host_sequencer;

    localparam int CNT_W  = 24;
    localparam int PAGE_W = 12;
    localparam int TBS    = 100;
    localparam int TBL    = 10;
    localparam int TRD    = 5;
    localparam int TRW    = 3;
    localparam int TST    = 20;
    localparam int TG     = 8;

    logic              master_clock = 1'b0;
    logic              power_good;
    logic              boot_start;
    logic              read_start;
    logic              abort;
    logic [PAGE_W-1:0] page_start;
    logic [PAGE_W-1:0] page_count;
    logic [CNT_W-1:0]  seek_delay;
    logic              bubble_shift_enable;
    logic              replicator_enable;
    logic              bootloop_enable;
    logic              busy;
    logic              done;
    logic [PAGE_W-1:0] page_addr;

    int   n_checks = 0;
    int   n_errors = 0;
    logic              m_boot = 1'b0;
    logic [PAGE_W-1:0] m_page = '0;

    always #5 master_clock = ~master_clock;

    bubble_host_sequencer #(
        .CNT_W        (CNT_W),
        .PAGE_W       (PAGE_W),
        .T_BOOT_SHIFT (TBS),
        .T_BOOT_LOOP  (TBL),
        .T_REP_DELAY  (TRD),
        .T_REP_WIDTH  (TRW),
        .T_SHIFT_TAIL (TST),
        .T_GAP        (TG)
    ) dut (
        .master_clock        (master_clock),
        .power_good          (power_good),
        .boot_start          (boot_start),
        .read_start          (read_start),
        .abort               (abort),
        .page_start          (page_start),
        .page_count          (page_count),
        .seek_delay          (seek_delay),
        .bubble_shift_enable (bubble_shift_enable),
        .replicator_enable   (replicator_enable),
        .bootloop_enable     (bootloop_enable),
        .busy                (busy),
        .done                (done),
        .page_addr           (page_addr)
    );

    // Observation vector: {bootloop, shift, replicator, busy, done, page_addr}
    function automatic logic [16:0] pack_obs();
        return {bootloop_enable, bubble_shift_enable, replicator_enable, busy, done, page_addr};
    endfunction

    function automatic logic [16:0] idle_vec(input logic b, input logic [11:0] p);
        return {b, 1'b1, 1'b1, 1'b0, 1'b0, p};
    endfunction

    // Expected outputs t cycles after the burst's first edge. Page k begins
    // at s_k; the first page leads with the seek delay, later ones with the
    // replicator delay; consecutive pages are separated by the gap.
    function automatic logic [16:0] exp_burst(input int t, input logic [11:0] start,
                                              input int count, input int se, input logic b);
        int s;
        s = 0;
        for (int k = 0; k < count; k++) begin
            int lead;
            int len;
            logic [11:0] pg;
            lead = (k == 0) ? se : TRD;
            len  = lead + TRW + TST;
            pg   = start + 12'(k);
            if (t < s) return {b, 1'b1, 1'b1, 1'b1, 1'b0, pg - 12'd1};
            if (t < s + len)
                return {b, 1'b0, !((t >= s + lead) && (t < s + lead + TRW)), 1'b1, 1'b0, pg};
            s = s + len + TG;
        end
        if (t == s - TG) return {b, 1'b1, 1'b1, 1'b0, 1'b1, start + 12'(count - 1)};
        return idle_vec(b, start + 12'(count - 1));
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Runs one burst and checks every cycle. abort_at >= 0 raises abort for
    // one cycle at that offset and expects an immediate return to idle.
    task automatic run_burst(input logic [11:0] start, input int count, input int seek,
                             input int abort_at, input string tag);
        int se;
        int e;
        logic [16:0] expv;
        logic [11:0] held;
        se   = (seek == 0) ? 1 : seek;
        e    = se + TRW + TST + (count - 1) * (TG + TRD + TRW + TST);
        held = m_page;
        @(negedge master_clock);
        read_start = 1'b1;
        page_start = start;
        page_count = 12'(count);
        seek_delay = CNT_W'(seek);
        @(negedge master_clock);
        read_start = 1'b0;
        for (int t = 0; t <= e + 2; t++) begin
            if (abort_at >= 0 && t > abort_at) expv = idle_vec(m_boot, held);
            else                               expv = exp_burst(t, start, count, se, m_boot);
            check($sformatf("%s t=%0d", tag, t), pack_obs(), expv);
            abort      = (t == abort_at);
            if (t == abort_at) held = expv[11:0];
            // Start requests while busy must be ignored.
            read_start = (abort_at < 0) && (t == 3);
            boot_start = (abort_at < 0) && (t == 3);
            if (abort_at >= 0 && t > abort_at + 3) break;
            @(negedge master_clock);
        end
        abort      = 1'b0;
        read_start = 1'b0;
        boot_start = 1'b0;
        m_page = (abort_at >= 0) ? held : (start + 12'(count - 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        power_good = 1'b0;
        boot_start = 1'b0;
        read_start = 1'b0;
        abort      = 1'b0;
        page_start = '0;
        page_count = '0;
        seek_delay = '0;

        // Reset and idle hold
        #12;
        check("reset values", pack_obs(), idle_vec(1'b0, 12'h000));
        @(negedge master_clock);
        power_good = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge master_clock);
            check($sformatf("idle hold c=%0d", i), pack_obs(), idle_vec(1'b0, 12'h000));
        end

        // Bootloader phase
        @(negedge master_clock);
        boot_start = 1'b1;
        read_start = 1'b1;
        page_count = 12'd1;
        @(negedge master_clock);
        boot_start = 1'b0;
        read_start = 1'b0;
        for (int t = 0; t <= TBS + TBL + 2; t++) begin
            check($sformatf("boot t=%0d", t), pack_obs(),
                  {m_boot | (t >= TBS + TBL), (t >= TBS), 1'b1, (t < TBS + TBL),
                   (t == TBS + TBL), m_page});
            @(negedge master_clock);
        end
        m_boot = 1'b1;

        // Directed bursts
        run_burst(12'h191, 3, 50, -1, "burst191");
        run_burst(12'hFFF, 2, $urandom_range(1, 40), -1, "wrap");

        // Zero page count: done pulse, shift never falls
        @(negedge master_clock);
        read_start = 1'b1;
        page_start = 12'(($urandom));
        page_count = '0;
        @(negedge master_clock);
        read_start = 1'b0;
        check("zero count done", pack_obs(), {m_boot, 1'b1, 1'b1, 1'b0, 1'b1, m_page});
        for (int i = 0; i < 5; i++) begin
            @(negedge master_clock);
            check($sformatf("zero count idle c=%0d", i), pack_obs(), idle_vec(m_boot, m_page));
        end

        run_burst(12'h020, 1, 0, -1, "seek0");

        // Abort during the first replicator pulse, then a normal burst
        run_burst(12'h0A5, 3, 10, 10, "abort");
        run_burst(12'(($urandom)), int'($urandom_range(1, 4)), int'($urandom_range(0, 40)), -1, "restart");

        for (int r = 0; r < 3; r++) begin
            run_burst(12'(($urandom)), int'($urandom_range(1, 4)), int'($urandom_range(0, 40)), -1,
                      $sformatf("rand%0d", r));
        end

        // Asynchronous reset in the middle of SHIFT_TAIL
        @(negedge master_clock);
        read_start = 1'b1;
        page_start = 12'h3C7;
        page_count = 12'd2;
        seek_delay = CNT_W'(7);
        @(negedge master_clock);
        read_start = 1'b0;
        repeat (7 + TRW + 4) @(negedge master_clock);
        check("pre-reset tail", pack_obs(), {m_boot, 1'b0, 1'b1, 1'b1, 1'b0, 12'h3C7});
        #2 power_good = 1'b0;
        #1 check("async reset", pack_obs(), idle_vec(1'b0, 12'h000));
        @(negedge master_clock);
        check("reset held", pack_obs(), idle_vec(1'b0, 12'h000));
        power_good = 1'b1;
        m_boot = 1'b0;
        m_page = '0;
        @(negedge master_clock);
        check("post-reset idle", pack_obs(), idle_vec(1'b0, 12'h000));
        run_burst(12'(($urandom)), 2, int'($urandom_range(0, 40)), -1, "post-reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
